// File: rtl/reg_vec_pkg.sv
// Shared types and helpers for the lane-vector serializer.
package reg_vec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Lane-index width; clamped to 1 so a degenerate count still yields a legal vector.
    function automatic int lane_idx_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/reg_vec_lane_bank.sv
// Bank of LANES lane registers with a common load enable and a lane-select read port.
module reg_vec_lane_bank
    import reg_vec_pkg::*;
#(
    parameter int LANES = 3,
    parameter int WIDTH = 3,
    parameter int IDXW  = lane_idx_w(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [LANES*WIDTH-1:0] i_data,
    input  logic [IDXW-1:0]        i_sel,
    output logic [WIDTH-1:0]       o_data
);

    logic [LANES-1:0][WIDTH-1:0] r_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
        end else if (i_load) begin
            r_lane <= i_data;
        end
    end

    assign o_data = r_lane[i_sel];

endmodule

// File: rtl/reg_vec_serializer.sv
// Accepts a full lane vector in one beat and drains it lane 0 first on a narrow valid/ready port.
module reg_vec_serializer
    import reg_vec_pkg::*;
#(
    parameter int LANES = 3,
    parameter int WIDTH = 3,
    parameter int IDXW  = lane_idx_w(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_last
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    state_t          r_state;
    state_t          w_state_nx;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] w_idx_nx;
    logic            w_last;
    logic            w_in_hs;
    logic            w_out_hs;

    assign w_last    = (r_state == SEND) && (r_idx == LAST_IDX);
    // out_ready feeds in_ready combinationally so a new vector can land on the final beat.
    assign in_ready  = !rst && ((r_state == IDLE) || (w_last && out_ready));
    assign out_valid = (r_state == SEND);
    assign out_idx   = r_idx;
    assign out_last  = w_last;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        if (w_out_hs) begin
            if (r_idx == LAST_IDX) begin
                w_idx_nx   = '0;
                w_state_nx = IDLE;
            end else begin
                w_idx_nx = r_idx + IDXW'(1);
            end
        end
        // A load wins over the drain-complete return to IDLE.
        if (w_in_hs) begin
            w_idx_nx   = '0;
            w_state_nx = SEND;
        end
    end

    reg_vec_lane_bank #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_in_hs),
        .i_data (in_data),
        .i_sel  (r_idx),
        .o_data (out_data)
    );

endmodule

// File: tb/tb_reg_vec_serializer.sv
// Directed and randomized checks of reg_vec_serializer against a beat-queue reference model.
module tb_reg_vec_serializer;

    localparam int L  = 3;
    localparam int W  = 3;
    localparam int IW = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [L*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_last;

    reg_vec_serializer #(.LANES(L), .WIDTH(W), .IDXW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           i;
    } beat_t;

    // Model: pending beats of the vector in flight, plus the last vector loaded.
    beat_t        mq[$];
    logic [W-1:0] held[L];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [L*W-1:0] d, input logic ordy);
        logic ev, erdy, elast, in_hs, out_hs;
        logic [W-1:0] edata;
        int eidx;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        ev    = (mq.size() != 0);
        erdy  = !r && ((mq.size() == 0) || ((mq.size() == 1) && ordy));
        edata = ev ? mq[0].d : held[0];
        eidx  = ev ? mq[0].i : 0;
        elast = ev && (mq[0].i == L - 1);
        chk("in_ready",  32'(in_ready),  32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data",  32'(out_data),  32'(edata));
        chk("out_idx",   32'(out_idx),   32'(eidx));
        chk("out_last",  32'(out_last),  32'(elast));
        in_hs  = iv && erdy;
        out_hs = ev && ordy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            for (int k = 0; k < L; k++) held[k] = '0;
        end else begin
            if (out_hs) void'(mq.pop_front());
            if (in_hs) begin
                for (int k = 0; k < L; k++) begin
                    held[k] = d[k*W +: W];
                    mq.push_back('{d: d[k*W +: W], i: k});
                end
            end
        end
    endtask

    localparam logic [L*W-1:0] V1 = {3'h5, 3'h2, 3'h7};
    localparam logic [L*W-1:0] V2 = {3'h1, 3'h3, 3'h4};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < L; k++) held[k] = '0;

        // Reset with a vector offered: nothing may be captured.
        repeat (3) cyc(1'b1, 1'b1, 9'h1FF, 1'b1);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Single vector drains as 7,2,5 then returns to IDLE.
        cyc(1'b0, 1'b1, V1, 1'b1);
        #1;
        chk("single_lane0", 32'(out_data), 32'd7);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Backpressure on lane 1, then a back-to-back vector on the final beat.
        cyc(1'b0, 1'b1, V1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("stall_data", 32'(out_data), 32'd2);
        chk("stall_idx",  32'(out_idx),  32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, V2, 1'b1);
        #1;
        chk("b2b_data",  32'(out_data),  32'd4);
        chk("b2b_idx",   32'(out_idx),   32'd0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);

        // Reset after lane 0 is accepted discards the rest.
        cyc(1'b0, 1'b1, V1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1);
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data",  32'(out_data),  32'd0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Offers during lanes 0-1 are ignored.
        cyc(1'b0, 1'b1, V2, 1'b1);
        cyc(1'b0, 1'b1, V1, 1'b1);
        cyc(1'b0, 1'b1, V1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 2) != 0),
                (L*W)'($urandom),
                ($urandom_range(0, 3) != 0));
        end
        repeat (4) cyc(1'b0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
